// File: rtl/audio_out_stream_writer_pkg.sv
// audio_out_stream_writer_pkg
// Shared definitions for the audio output stream writer and its per-channel
// gain/saturate datapath.
//   state_t      : sequencer states (IDLE, MUL, SAT, WAIT, HOLD)
//   GAIN_ONE     : Q1.15 unity gain
//   GAIN_SHIFT   : fractional bits of the gain
//   FIFO_DEPTH   : write_space value meaning "FIFO completely empty"
//   HOLD_CYCLES  : cycles spent after a write before accepting the next pair
package audio_out_stream_writer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        SAT  = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [15:0] GAIN_ONE    = 16'h8000;
    localparam int          GAIN_SHIFT  = 15;
    localparam logic [7:0]  FIFO_DEPTH  = 8'd128;
    localparam int          HOLD_CYCLES = 3;

endpackage

// File: rtl/audio_gain_saturate.sv
// audio_gain_saturate
// One channel of the output datapath: registered signed x Q1.15 multiply,
// then floor shift, saturation to the input sample range, optional mute and
// left-justification into the serializer word.
//   clk, reset : clock, synchronous active-high reset
//   mul_en     : load the product register
//   sat_en     : load the output word register
//   sample     : signed input sample
//   gain       : unsigned Q1.15 gain
//   mute       : force the word to zero and suppress the clip flag
//   word       : left-justified, registered output word
//   clip       : combinational, high when the current product saturates
module audio_gain_saturate
    import audio_out_stream_writer_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 32,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mul_en,
    input  logic                  sat_en,
    input  logic [IN_WIDTH-1:0]   sample,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  mute,
    output logic [OUT_WIDTH-1:0]  word,
    output logic                  clip
);

    localparam int PROD_WIDTH = IN_WIDTH + GAIN_WIDTH + 1;

    // Limits of a signed IN_WIDTH value, sign-extended to product width.
    localparam logic signed [PROD_WIDTH-1:0] SAT_MAX =
        {{(PROD_WIDTH-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_WIDTH-1:0] SAT_MIN =
        {{(PROD_WIDTH-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

    logic signed [PROD_WIDTH-1:0] sample_ext;
    logic signed [PROD_WIDTH-1:0] gain_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] shifted;
    logic        [IN_WIDTH-1:0]   result;
    logic        [OUT_WIDTH-1:0]  justified;

    // Gain is unsigned, so it gets a zero sign bit; operands are pre-extended
    // so the full-width product is exact.
    assign sample_ext = {{(GAIN_WIDTH+1){sample[IN_WIDTH-1]}}, sample};
    assign gain_ext   = {{(IN_WIDTH+1){1'b0}}, gain};

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
        end else if (mul_en) begin
            product <= sample_ext * gain_ext;
        end
    end

    // Arithmetic shift gives floor rounding for negative products.
    assign shifted = product >>> GAIN_SHIFT;

    always_comb begin
        result    = shifted[IN_WIDTH-1:0];
        clip      = 1'b0;
        justified = '0;
        if (mute) begin
            result = '0;
        end else if (shifted > SAT_MAX) begin
            result = SAT_MAX[IN_WIDTH-1:0];
            clip   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[IN_WIDTH-1:0];
            clip   = 1'b1;
        end
        justified[OUT_WIDTH-1 -: IN_WIDTH] = result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (sat_en) begin
            word <= justified;
        end
    end

endmodule

// File: rtl/audio_out_stream_writer.sv
// audio_out_stream_writer
// Feeds the DAC serializer: accepts stereo pairs over valid/ready, applies
// gain/mute/saturation per channel and writes both words into the left/right
// FIFOs in the same cycle once both have space. Tracks clips and underrun.
//   clk, reset                       : clock, synchronous active-high reset
//   in_left, in_right, in_valid      : signed sample pair and its valid
//   in_ready                         : registered, high only in IDLE
//   gain_left, gain_right, mute      : sampled when a pair is accepted
//   clear_status                     : clears clip_count and underrun
//   *_channel_fifo_write_space       : free words in each FIFO (0..128)
//   *_channel_data, *_channel_data_en: FIFO words and shared write strobe
//   clip_count                       : saturating count of clipped samples
//   underrun                         : sticky, a FIFO emptied after streaming
module audio_out_stream_writer
    import audio_out_stream_writer_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 32,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   in_left,
    input  logic [IN_WIDTH-1:0]   in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [GAIN_WIDTH-1:0] gain_left,
    input  logic [GAIN_WIDTH-1:0] gain_right,
    input  logic                  mute,
    input  logic                  clear_status,
    input  logic [7:0]            left_channel_fifo_write_space,
    input  logic [7:0]            right_channel_fifo_write_space,
    output logic [OUT_WIDTH-1:0]  left_channel_data,
    output logic                  left_channel_data_en,
    output logic [OUT_WIDTH-1:0]  right_channel_data,
    output logic                  right_channel_data_en,
    output logic [15:0]           clip_count,
    output logic                  underrun
);

    state_t                  state;
    logic [1:0]              hold_cnt;
    logic                    data_en;
    logic                    started;
    logic [IN_WIDTH-1:0]     cap_left;
    logic [IN_WIDTH-1:0]     cap_right;
    logic [GAIN_WIDTH-1:0]   cap_gain_left;
    logic [GAIN_WIDTH-1:0]   cap_gain_right;
    logic                    cap_mute;
    logic                    clip_left;
    logic                    clip_right;
    logic [16:0]             clip_sum;
    logic [15:0]             clip_next;

    audio_gain_saturate #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .mul_en (state == MUL),
        .sat_en (state == SAT),
        .sample (cap_left),
        .gain   (cap_gain_left),
        .mute   (cap_mute),
        .word   (left_channel_data),
        .clip   (clip_left)
    );

    audio_gain_saturate #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .mul_en (state == MUL),
        .sat_en (state == SAT),
        .sample (cap_right),
        .gain   (cap_gain_right),
        .mute   (cap_mute),
        .word   (right_channel_data),
        .clip   (clip_right)
    );

    // Both FIFOs are always written together, so one strobe drives both.
    assign left_channel_data_en  = data_en;
    assign right_channel_data_en = data_en;

    // HOLD covers the strobe cycle plus the FIFOs' write_space update
    // latency, so the next WAIT never decides on a stale space value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            data_en        <= 1'b0;
            started        <= 1'b0;
            hold_cnt       <= '0;
            cap_left       <= '0;
            cap_right      <= '0;
            cap_gain_left  <= '0;
            cap_gain_right <= '0;
            cap_mute       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_en <= 1'b0;
                    if (in_valid && in_ready) begin
                        cap_left       <= in_left;
                        cap_right      <= in_right;
                        cap_gain_left  <= gain_left;
                        cap_gain_right <= gain_right;
                        cap_mute       <= mute;
                        in_ready       <= 1'b0;
                        state          <= MUL;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    state <= SAT;
                end
                SAT: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if ((left_channel_fifo_write_space != 8'd0) &&
                        (right_channel_fifo_write_space != 8'd0)) begin
                        data_en  <= 1'b1;
                        started  <= 1'b1;
                        hold_cnt <= 2'(HOLD_CYCLES - 1);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    data_en <= 1'b0;
                    if (hold_cnt == 2'd0) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                    end
                end
                default: begin
                    data_en  <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        clip_sum  = {1'b0, clip_count} + {16'b0, clip_left} + {16'b0, clip_right};
        clip_next = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end

    // clear_status has priority over a same-cycle clip or underrun event.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count <= '0;
            underrun   <= 1'b0;
        end else begin
            if (clear_status) begin
                clip_count <= '0;
            end else if (state == SAT) begin
                clip_count <= clip_next;
            end
            if (clear_status) begin
                underrun <= 1'b0;
            end else if (started &&
                         ((left_channel_fifo_write_space == FIFO_DEPTH) ||
                          (right_channel_fifo_write_space == FIFO_DEPTH))) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_out_stream_writer.sv
// tb_audio_out_stream_writer
// Directed bench for audio_out_stream_writer with a transaction-timed
// reference model compared against the DUT on every falling edge, plus
// hand-computed literal expectations for each scenario.
module tb_audio_out_stream_writer;
    import audio_out_stream_writer_pkg::*;

    localparam int IN_W   = 24;
    localparam int OUT_W  = 32;
    localparam int GAIN_W = 16;

    logic              clk;
    logic              reset;
    logic [IN_W-1:0]   in_left;
    logic [IN_W-1:0]   in_right;
    logic              in_valid;
    logic              in_ready;
    logic [GAIN_W-1:0] gain_left;
    logic [GAIN_W-1:0] gain_right;
    logic              mute;
    logic              clear_status;
    logic [7:0]        lsp;
    logic [7:0]        rsp;
    logic [OUT_W-1:0]  left_data;
    logic              left_en;
    logic [OUT_W-1:0]  right_data;
    logic              right_en;
    logic [15:0]       clip_count;
    logic              underrun;

    audio_out_stream_writer #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .GAIN_WIDTH (GAIN_W)
    ) dut (
        .clk                            (clk),
        .reset                          (reset),
        .in_left                        (in_left),
        .in_right                       (in_right),
        .in_valid                       (in_valid),
        .in_ready                       (in_ready),
        .gain_left                      (gain_left),
        .gain_right                     (gain_right),
        .mute                           (mute),
        .clear_status                   (clear_status),
        .left_channel_fifo_write_space  (lsp),
        .right_channel_fifo_write_space (rsp),
        .left_channel_data              (left_data),
        .left_channel_data_en           (left_en),
        .right_channel_data             (right_data),
        .right_channel_data_en          (right_en),
        .clip_count                     (clip_count),
        .underrun                       (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    // Reference model state: expected output values after each rising edge.
    logic        m_ready = 1'b0;
    logic        m_en = 1'b0;
    logic        m_started = 1'b0;
    logic        m_underrun = 1'b0;
    logic [31:0] m_left = '0;
    logic [31:0] m_right = '0;
    int          m_clip = 0;
    bit          busy = 1'b0;
    bit          strobed = 1'b0;
    int          age = 0;
    int          since = 0;
    logic [31:0] pend_l = '0;
    logic [31:0] pend_r = '0;
    int          pend_clips = 0;
    int          inc = 0;
    bit          old_started = 1'b0;
    int          cl = 0;
    int          cr = 0;

    // Gain, floor, clamp and justify using plain integer arithmetic.
    function automatic logic [31:0] modelWord(input logic [23:0] s, input logic [15:0] g,
                                              input logic mu, output int clipped);
        longint p;
        longint q;
        longint hi;
        longint lo;
        logic [23:0] r;
        hi = (longint'(1) <<< (IN_W - 1)) - 1;
        lo = -(longint'(1) <<< (IN_W - 1));
        p = longint'($signed(s)) * longint'(g);
        q = p >>> 15;
        clipped = 0;
        if (mu) begin
            q = 0;
        end else if (q > hi) begin
            q = hi;
            clipped = 1;
        end else if (q < lo) begin
            q = lo;
            clipped = 1;
        end
        r = q[23:0];
        return {r, 8'h00};
    endfunction

    // Model timeline: a pair accepted at edge A lands on the data outputs at
    // A+2, may be written from A+3 on once both FIFOs have room, and the
    // block accepts again three edges after the write.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_ready = 1'b0; m_en = 1'b0; m_started = 1'b0; m_underrun = 1'b0;
                m_left = '0; m_right = '0; m_clip = 0; busy = 1'b0; strobed = 1'b0;
            end else begin
                old_started = m_started;
                inc = 0;
                m_en = 1'b0;
                if (!busy) begin
                    if (in_valid && m_ready) begin
                        busy = 1'b1; age = 0; strobed = 1'b0; since = 0;
                        pend_l = modelWord(in_left, gain_left, mute, cl);
                        pend_r = modelWord(in_right, gain_right, mute, cr);
                        pend_clips = cl + cr;
                        m_ready = 1'b0;
                    end else begin
                        m_ready = 1'b1;
                    end
                end else begin
                    age++;
                    if (age == 2) begin
                        m_left = pend_l; m_right = pend_r; inc = pend_clips;
                    end
                    if (!strobed) begin
                        if (age >= 3 && lsp != 0 && rsp != 0) begin
                            m_en = 1'b1; strobed = 1'b1; since = 0; m_started = 1'b1;
                        end
                    end else begin
                        since++;
                        if (since == 3) begin
                            busy = 1'b0; m_ready = 1'b1;
                        end
                    end
                end
                if (clear_status) m_clip = 0;
                else m_clip = (m_clip + inc > 65535) ? 65535 : m_clip + inc;
                if (clear_status) m_underrun = 1'b0;
                else if (old_started && (lsp == 8'd128 || rsp == 8'd128)) m_underrun = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_on) begin
                checkOutput("cmp_in_ready", {31'b0, in_ready}, {31'b0, m_ready});
                checkOutput("cmp_left_en", {31'b0, left_en}, {31'b0, m_en});
                checkOutput("cmp_right_en", {31'b0, right_en}, {31'b0, m_en});
                checkOutput("cmp_left_data", left_data, m_left);
                checkOutput("cmp_right_data", right_data, m_right);
                checkOutput("cmp_clip_count", {16'b0, clip_count}, 32'(m_clip));
                checkOutput("cmp_underrun", {31'b0, underrun}, {31'b0, m_underrun});
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_ready: got timeout expected ready within 100 cycles");
        end
    endtask

    // Presents one pair for a single cycle while the block is ready; returns
    // on the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r,
                                 input logic [15:0] gl, input logic [15:0] gr, input logic mu);
        waitIdle();
        in_left = l; in_right = r; gain_left = gl; gain_right = gr; mute = mu;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Runs one pair with both FIFOs open and checks the strobe cycle.
    task automatic runPair(input string name, input logic [23:0] l, input logic [23:0] r,
                           input logic [15:0] gl, input logic [15:0] gr, input logic mu,
                           input logic [31:0] exp_l, input logic [31:0] exp_r,
                           input logic [15:0] exp_clip);
        applyStimulus(l, r, gl, gr, mu);
        repeat (3) @(negedge clk);
        checkOutput({name, "_left"}, left_data, exp_l);
        checkOutput({name, "_right"}, right_data, exp_r);
        checkOutput({name, "_strobe"}, {31'b0, left_en & right_en}, 32'd1);
        checkOutput({name, "_clip"}, {16'b0, clip_count}, {16'b0, exp_clip});
        @(negedge clk);
        checkOutput({name, "_strobe_off"}, {31'b0, left_en | right_en}, 32'd0);
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
        gain_left = GAIN_ONE; gain_right = GAIN_ONE; mute = 1'b0;
        clear_status = 1'b0; lsp = 8'd64; rsp = 8'd64;
        repeat (2) @(negedge clk);
        check_on = 1'b1;
        checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_en", {31'b0, left_en | right_en}, 32'd0);
        checkOutput("rst_clip", {16'b0, clip_count}, 32'd0);
        checkOutput("rst_data", left_data | right_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'b0, in_ready}, 32'd1);

        runPair("unity", 24'h123456, 24'hFEDCBA, 16'h8000, 16'h8000, 1'b0,
                32'h12345600, 32'hFEDCBA00, 16'd0);
        runPair("half", 24'h400000, 24'hC00000, 16'h4000, 16'h4000, 1'b0,
                32'h20000000, 32'hE0000000, 16'd0);
        runPair("clip", 24'h7FFFFF, 24'h800000, 16'hFFFF, 16'hFFFF, 1'b0,
                32'h7FFFFF00, 32'h80000000, 16'd2);
        runPair("mute", 24'h7FFFFF, 24'h800000, 16'hFFFF, 16'hFFFF, 1'b1,
                32'h00000000, 32'h00000000, 16'd2);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checkOutput("clear_clip", {16'b0, clip_count}, 32'd0);
        runPair("gain0", 24'h7FFFFF, 24'h800000, 16'h0000, 16'h0000, 1'b0,
                32'h00000000, 32'h00000000, 16'd0);
        runPair("gainmax", 24'h100000, 24'hF00000, 16'hFFFF, 16'hFFFF, 1'b0,
                32'h1FFFE000, 32'hE0002000, 16'd0);
        runPair("floor", 24'h000001, 24'hFFFFFF, 16'h4000, 16'h4000, 1'b0,
                32'h00000000, 32'hFFFFFF00, 16'd0);

        // Backpressure: right FIFO full for a long stretch.
        rsp = 8'd0;
        applyStimulus(24'h010203, 24'h040506, GAIN_ONE, GAIN_ONE, 1'b0);
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            checkOutput("bp_no_strobe", {31'b0, left_en | right_en}, 32'd0);
            checkOutput("bp_not_ready", {31'b0, in_ready}, 32'd0);
        end
        rsp = 8'd1;
        @(negedge clk);
        checkOutput("bp_strobe", {31'b0, left_en & right_en}, 32'd1);
        checkOutput("bp_data", right_data, 32'h04050600);
        @(negedge clk);
        checkOutput("bp_hold1_en", {31'b0, left_en | right_en}, 32'd0);
        checkOutput("bp_hold1_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("bp_hold2_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("bp_ready_again", {31'b0, in_ready}, 32'd1);
        rsp = 8'd64;

        // Underrun after streaming has started.
        checkOutput("ur_clear", {31'b0, underrun}, 32'd0);
        lsp = 8'd128;
        @(negedge clk);
        checkOutput("ur_set", {31'b0, underrun}, 32'd1);
        runPair("ur_write", 24'h000100, 24'h000200, GAIN_ONE, GAIN_ONE, 1'b0,
                32'h00010000, 32'h00020000, 16'd0);
        checkOutput("ur_sticky", {31'b0, underrun}, 32'd1);
        lsp = 8'd64;
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checkOutput("ur_cleared", {31'b0, underrun}, 32'd0);

        // Reset while a pair waits for FIFO space.
        rsp = 8'd0;
        applyStimulus(24'h0ABCDE, 24'h0FEDCB, GAIN_ONE, GAIN_ONE, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_en", {31'b0, left_en | right_en}, 32'd0);
        checkOutput("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("mid_rst_data", left_data | right_data, 32'd0);
        checkOutput("mid_rst_status", {15'b0, clip_count, underrun}, 32'd0);
        rsp = 8'd64;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("after_rst_no_stale", {31'b0, left_en | right_en}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
